// File: rtl/baser_66b_encoder_if.sv
// rtl/baser_66b_encoder_if.sv - MII word in / 66b coded block out bundle for the 64B/66B encoder
interface baser_66b_encoder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  localparam int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam int CTRL_WIDTH  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]  i_txd;
  logic [CTRL_WIDTH-1:0]  i_txc;
  logic [FRAME_WIDTH-1:0] o_tx_coded;

  // MII source side: drives the word and control lanes, observes coded blocks
  modport master (
    output i_txd,
    output i_txc,
    input  o_tx_coded
  );

  // Encoder side
  modport slave (
    input  i_txd,
    input  i_txc,
    output o_tx_coded
  );
endinterface

// File: rtl/baser_66b_encoder.sv
// rtl/baser_66b_encoder.sv - 1.6TMII to 64B/66B transmit encoder; BASER_TX_FSM_EN enables the transmit sequence FSM
module baser_66b_encoder #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  baser_66b_encoder_if.slave    mii,
  output logic [31:0]           o_block_count,
  output logic [31:0]           o_data_count,
  output logic [31:0]           o_ctrl_count,
  output logic [31:0]           o_err_block_count,
  output logic [31:0]           o_seq_err_count
);

  localparam logic [HDR_WIDTH-1:0]   SH_DATA    = 2'b10;
  localparam logic [HDR_WIDTH-1:0]   SH_CTRL    = 2'b01;
  localparam logic [FRAME_WIDTH-1:0] IDLE_BLOCK = {56'h0, 8'h1E, SH_CTRL};
  localparam logic [FRAME_WIDTH-1:0] E_BLOCK    = {{8{7'h1E}}, 8'h1E, SH_CTRL};

  typedef enum logic [2:0] {
    CLS_C,
    CLS_S,
    CLS_D,
    CLS_T,
    CLS_E
  } blk_class_t;

  // Only idle (0x07) and error (0xFE) are legal filler control characters
  function automatic logic idle_char(input logic [7:0] c);
    return (c == 8'h07) || (c == 8'hFE);
  endfunction

  // 8-bit MII control character to its 7-bit 66b code
  function automatic logic [6:0] map_char(input logic [7:0] c);
    return (c == 8'hFE) ? 7'h1E : 7'h00;
  endfunction

  // Block type for a terminate in lane n
  function automatic logic [7:0] term_type(input int n);
    logic [7:0] t;
    case (n)
      0:       t = 8'h87;
      1:       t = 8'h99;
      2:       t = 8'hAA;
      3:       t = 8'hB4;
      4:       t = 8'hCC;
      5:       t = 8'hD2;
      6:       t = 8'hE1;
      default: t = 8'hFF;
    endcase
    return t;
  endfunction

  logic [7:0]             lane [CTRL_WIDTH];
  blk_class_t             cls;
  logic [55:0]            payload;
  logic                   all_idle;
  logic                   tail_ok;
  logic [FRAME_WIDTH-1:0] enc;
  logic                   legal;
  logic [FRAME_WIDTH-1:0] tx_coded_q;

  // Split the MII word into byte lanes, lane 0 first on the wire
  always_comb begin
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      lane[k] = mii.i_txd[8*k +: 8];
    end
  end

  // Classify the MII word and build its coded block assuming the transition is legal
  always_comb begin
    cls      = CLS_E;
    enc      = E_BLOCK;
    payload  = '0;
    all_idle = 1'b1;
    tail_ok  = 1'b0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      all_idle = all_idle & idle_char(lane[k]);
    end

    if ((mii.i_txc == 8'hFF) && all_idle) begin
      for (int k = 0; k < CTRL_WIDTH; k++) begin
        payload[7*k +: 7] = map_char(lane[k]);
      end
      cls = CLS_C;
      enc = {payload, 8'h1E, SH_CTRL};
    end else if ((mii.i_txc == 8'hF1) && (lane[0] == 8'h9C)) begin
      // Ordered set in the first half; the second half of the word is not carried
      cls = CLS_C;
      enc = {28'h0, 4'h0, mii.i_txd[31:8], 8'h4B, SH_CTRL};
    end else if ((mii.i_txc == 8'h01) && (lane[0] == 8'hFB)) begin
      cls = CLS_S;
      enc = {mii.i_txd[63:8], 8'h78, SH_CTRL};
    end else if (mii.i_txc == 8'h00) begin
      cls = CLS_D;
      enc = {mii.i_txd, SH_DATA};
    end else begin
      for (int n = 0; n < CTRL_WIDTH; n++) begin
        tail_ok = (mii.i_txc == (8'hFF << n)) && (lane[n] == 8'hFD);
        for (int j = 0; j < CTRL_WIDTH; j++) begin
          if (j > n) begin
            tail_ok = tail_ok & idle_char(lane[j]);
          end
        end
        if (tail_ok) begin
          // Data lanes pack from bit 0; the trailing control chars land at 7*j,
          // which leaves exactly (7-n) zero pad bits between the two groups
          payload = '0;
          for (int j = 0; j < CTRL_WIDTH; j++) begin
            if (j < n) begin
              payload[8*j +: 8] = lane[j];
            end else if (j > n) begin
              payload[7*j +: 7] = map_char(lane[j]);
            end
          end
          cls = CLS_T;
          enc = {payload, term_type(n), SH_CTRL};
        end
      end
    end
  end

`ifdef BASER_TX_FSM_EN
  typedef enum logic [2:0] {
    TX_INIT,
    TX_C,
    TX_D,
    TX_T,
    TX_E
  } tx_state_t;

  tx_state_t state;
  tx_state_t next_state;
  logic      seq_err;

  // Legal block sequencing; anything else forces an E block and TX_E
  always_comb begin
    legal      = 1'b0;
    next_state = TX_E;
    case (state)
      TX_D: begin
        if (cls == CLS_D) begin
          legal      = 1'b1;
          next_state = TX_D;
        end else if (cls == CLS_T) begin
          legal      = 1'b1;
          next_state = TX_T;
        end
      end
      TX_E: begin
        if (cls == CLS_C) begin
          legal      = 1'b1;
          next_state = TX_C;
        end else if (cls == CLS_D) begin
          legal      = 1'b1;
          next_state = TX_D;
        end else if (cls == CLS_T) begin
          legal      = 1'b1;
          next_state = TX_T;
        end
      end
      default: begin
        if (cls == CLS_C) begin
          legal      = 1'b1;
          next_state = TX_C;
        end else if (cls == CLS_S) begin
          legal      = 1'b1;
          next_state = TX_D;
        end
      end
    endcase
    // A well-formed block arriving out of order is a sequence error, malformed input is not
    seq_err = !legal && (cls != CLS_E);
  end
`else
  assign legal           = (cls != CLS_E);
  assign o_seq_err_count = '0;
`endif

  // Register the coded block, the sequencing state and all block counters
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      tx_coded_q        <= IDLE_BLOCK;
      o_block_count     <= '0;
      o_data_count      <= '0;
      o_ctrl_count      <= '0;
      o_err_block_count <= '0;
`ifdef BASER_TX_FSM_EN
      state             <= TX_INIT;
      o_seq_err_count   <= '0;
`endif
    end else begin
      tx_coded_q    <= legal ? enc : E_BLOCK;
      o_block_count <= o_block_count + 32'd1;
      if (legal && (cls == CLS_D)) begin
        o_data_count <= o_data_count + 32'd1;
      end else begin
        o_ctrl_count <= o_ctrl_count + 32'd1;
      end
      if (!legal) begin
        o_err_block_count <= o_err_block_count + 32'd1;
      end
`ifdef BASER_TX_FSM_EN
      state <= legal ? next_state : TX_E;
      if (seq_err) begin
        o_seq_err_count <= o_seq_err_count + 32'd1;
      end
`endif
    end
  end

  assign mii.o_tx_coded = tx_coded_q;

endmodule
